bulls_cows_match: RTL and testbench

BULLS_COWS_MATCH -- requirements
Module: bulls_cows_match

---
 rtl/bulls_cows_pkg.sv | 14 +
 rtl/bc_digit_scan.sv | 23 ++
 rtl/bulls_cows_match.sv | 137 +++++++++++++
 tb/tb_bulls_cows_match.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bulls_cows_pkg.sv
// bulls_cows_pkg: FSM state encoding shared by the match controller and its bench.
package bulls_cows_pkg;
    localparam int PHASE_W = 3;
    typedef enum logic [PHASE_W-1:0] {
        S1    = 3'd0,
        S2    = 3'd1,
        T1    = 3'd2,
        T2    = 3'd3,
        CHECK = 3'd4,
        SCORE = 3'd5,
        WIN   = 3'd6,
        OVER  = 3'd7
    } phase_t;
endpackage

// File: rtl/bc_digit_scan.sv
// bc_digit_scan: compares one digit against a digit vector, split into hit at index and hit elsewhere.
module bc_digit_scan #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int IDX_W   = 2
) (
    input  logic [DIGIT_W-1:0]        i_digit,
    input  logic [DIGITS*DIGIT_W-1:0] i_vec,
    input  logic [IDX_W-1:0]          i_idx,
    output logic                      o_at_idx,
    output logic                      o_elsewhere
);
    always_comb begin
        o_at_idx    = 1'b0;
        o_elsewhere = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (i_vec[j*DIGIT_W +: DIGIT_W] == i_digit) begin
                if (IDX_W'(j) == i_idx) o_at_idx = 1'b1;
                else o_elsewhere = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bulls_cows_match.sv
// bulls_cows_match: two-player bulls and cows match controller.
// Codes are validated and scored one digit per cycle through a single shared scanner.
module bulls_cows_match import bulls_cows_pkg::*; #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_DIGIT    = 9,
    parameter int POINTS_W     = 4,
    parameter int MATCH_POINTS = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [DIGITS*DIGIT_W-1:0]     i_code,
    input  logic                          i_enter_button,
    output logic [PHASE_W-1:0]            o_phase,
    output logic [$clog2(DIGITS+1)-1:0]   o_bulls,
    output logic [$clog2(DIGITS+1)-1:0]   o_cows,
    output logic                          o_result_valid,
    output logic                          o_code_error,
    output logic                          o_winner,
    output logic [POINTS_W-1:0]           o_p1_points,
    output logic [POINTS_W-1:0]           o_p2_points,
    output logic                          o_busy
);
    localparam int CW     = $clog2(DIGITS+1);
    localparam int IW     = $clog2(DIGITS);
    localparam int CODE_W = DIGITS*DIGIT_W;

    phase_t              r_state, r_ret;
    logic [CODE_W-1:0]   r_cap, r_secret1, r_secret2;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_bull_acc, r_cow_acc;
    logic                r_fail, r_enter_d;

    logic [DIGIT_W-1:0]  w_digit;
    logic [CODE_W-1:0]   w_vec;
    logic                w_at_idx, w_elsewhere, w_edge, w_last, w_bad, w_won;
    logic [CW-1:0]       w_bulls, w_cows;
    logic [POINTS_W-1:0] w_cur_pts, w_pts;

    assign w_edge  = i_enter_button & ~r_enter_d;
    assign w_last  = r_idx == IW'(DIGITS-1);
    assign w_digit = r_cap[r_idx*DIGIT_W +: DIGIT_W];
    // CHECK scans the capture against itself; SCORE scans it against the opponent's secret
    assign w_vec   = (r_state == CHECK) ? r_cap : ((r_ret == T1) ? r_secret2 : r_secret1);
    assign w_bad   = r_fail | w_elsewhere | (w_digit > DIGIT_W'(MAX_DIGIT));
    assign w_bulls = r_bull_acc + CW'(w_at_idx);
    assign w_cows  = r_cow_acc + CW'(!w_at_idx && w_elsewhere);
    assign w_won   = w_bulls == CW'(DIGITS);
    assign w_cur_pts = (r_ret == T2) ? o_p2_points : o_p1_points;
    assign w_pts   = (&w_cur_pts) ? w_cur_pts : w_cur_pts + 1'b1;
    assign o_phase = r_state;
    assign o_busy  = (r_state == CHECK) || (r_state == SCORE);

    bc_digit_scan #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .IDX_W(IW)) u_scan (
        .i_digit     (w_digit),
        .i_vec       (w_vec),
        .i_idx       (r_idx),
        .o_at_idx    (w_at_idx),
        .o_elsewhere (w_elsewhere)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= S1;
            r_ret          <= S1;
            r_cap          <= '0;
            r_secret1      <= '0;
            r_secret2      <= '0;
            r_idx          <= '0;
            r_bull_acc     <= '0;
            r_cow_acc      <= '0;
            r_fail         <= 1'b0;
            r_enter_d      <= 1'b0;
            o_bulls        <= '0;
            o_cows         <= '0;
            o_result_valid <= 1'b0;
            o_code_error   <= 1'b0;
            o_winner       <= 1'b0;
            o_p1_points    <= '0;
            o_p2_points    <= '0;
        end else begin
            r_enter_d      <= i_enter_button;
            o_result_valid <= 1'b0;
            o_code_error   <= 1'b0;
            case (r_state)
                S1, S2, T1, T2: if (w_edge) begin
                    r_cap      <= i_code;
                    r_ret      <= r_state;
                    r_idx      <= '0;
                    r_fail     <= 1'b0;
                    r_bull_acc <= '0;
                    r_cow_acc  <= '0;
                    r_state    <= CHECK;
                end
                CHECK: begin
                    r_fail <= w_bad;
                    r_idx  <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        if (w_bad) begin
                            o_code_error <= 1'b1;
                            r_state      <= r_ret;
                        end else if (r_ret == S1) begin
                            r_secret1 <= r_cap;
                            r_state   <= S2;
                        end else if (r_ret == S2) begin
                            r_secret2 <= r_cap;
                            r_state   <= T1;
                        end else r_state <= SCORE;
                    end
                end
                SCORE: begin
                    r_bull_acc <= w_bulls;
                    r_cow_acc  <= w_cows;
                    r_idx      <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        o_bulls        <= w_bulls;
                        o_cows         <= w_cows;
                        o_result_valid <= 1'b1;
                        if (w_won) begin
                            o_winner <= r_ret == T2;
                            if (r_ret == T2) o_p2_points <= w_pts;
                            else o_p1_points <= w_pts;
                            r_state <= (w_pts >= POINTS_W'(MATCH_POINTS)) ? OVER : WIN;
                        end else r_state <= (r_ret == T1) ? T2 : T1;
                    end
                end
                WIN: if (w_edge) begin
                    r_secret1 <= '0;
                    r_secret2 <= '0;
                    r_state   <= S1;
                end
                OVER: r_state <= OVER;
                default: r_state <= S1;
            endcase
        end
    end
endmodule

// File: tb/tb_bulls_cows_match.sv
// tb_bulls_cows_match: vector table, corner sequences and a randomized game against a move-level model.
module tb_bulls_cows_match;
    import bulls_cows_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, enter = 1'b0;
    logic [15:0] code = '0;
    logic [2:0]  phase, phase2, bulls, cows, bulls2, cows2;
    logic        rv, ce, win, busy, rv2, ce2, win2, busy2;
    logic [3:0]  p1, p2, p1b, p2b;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    bulls_cows_match dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_code(code), .i_enter_button(enter),
        .o_phase(phase), .o_bulls(bulls), .o_cows(cows), .o_result_valid(rv),
        .o_code_error(ce), .o_winner(win), .o_p1_points(p1), .o_p2_points(p2), .o_busy(busy)
    );

    bulls_cows_match #(.MATCH_POINTS(2)) dut2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_code(code), .i_enter_button(enter),
        .o_phase(phase2), .o_bulls(bulls2), .o_cows(cows2), .o_result_valid(rv2),
        .o_code_error(ce2), .o_winner(win2), .o_p1_points(p1b), .o_p2_points(p2b), .o_busy(busy2)
    );

    phase_t      m_phase;
    logic [15:0] m_s1, m_s2;
    int          m_b, m_c, m_p1, m_p2;
    bit          m_win;

    typedef struct {
        logic [15:0] code;
        bit          err;
        bit          val;
        int          b;
        int          c;
        phase_t      ph;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int dg(input logic [15:0] c, input int i);
        return int'(c[i*4 +: 4]);
    endfunction

    function automatic bit legal(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            if (dg(c, i) > 9) return 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (dg(c, i) == dg(c, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void score(input logic [15:0] g, input logic [15:0] s, output int b, output int c);
        bit other;
        b = 0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            other = 1'b0;
            for (int j = 0; j < 4; j++)
                if (j != i && dg(s, j) == dg(g, i)) other = 1'b1;
            if (dg(g, i) == dg(s, i)) b++;
            else if (other) c++;
        end
    endfunction

    function automatic logic [15:0] rand_legal();
        int d[10];
        int j, t;
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < 10; i++) d[i] = i;
        for (int i = 0; i < 4; i++) begin
            j = int'($urandom_range(9, i));
            t = d[i]; d[i] = d[j]; d[j] = t;
            c[i*4 +: 4] = 4'(d[i]);
        end
        return c;
    endfunction

    task automatic model_press(input logic [15:0] c, output bit e_err, output bit e_val);
        e_err = 1'b0;
        e_val = 1'b0;
        if (m_phase inside {S1, S2, T1, T2}) begin
            if (!legal(c)) e_err = 1'b1;
            else if (m_phase == S1) begin m_s1 = c; m_phase = S2; end
            else if (m_phase == S2) begin m_s2 = c; m_phase = T1; end
            else begin
                score(c, (m_phase == T1) ? m_s2 : m_s1, m_b, m_c);
                e_val = 1'b1;
                if (m_b == 4) begin
                    m_win = (m_phase == T2);
                    if (m_win && m_p2 < 15) m_p2++;
                    if (!m_win && m_p1 < 15) m_p1++;
                    m_phase = (m_p1 >= 3 || m_p2 >= 3) ? OVER : WIN;
                end else m_phase = (m_phase == T1) ? T2 : T1;
            end
        end else if (m_phase == WIN) begin
            m_s1 = '0;
            m_s2 = '0;
            m_phase = S1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        enter = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = S1; m_s1 = '0; m_s2 = '0;
        m_b = 0; m_c = 0; m_p1 = 0; m_p2 = 0; m_win = 1'b0;
    endtask

    task automatic press(input logic [15:0] c);
        @(negedge clk);
        code  = c;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic settle(output bit got_v, output bit got_e, output int lat);
        got_v = 1'b0;
        got_e = 1'b0;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            got_v |= rv;
            got_e |= ce;
        end while (busy && lat < 40);
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL settle: busy still high after %0d cycles", lat);
        end
    endtask

    initial begin
        bit gv, ge, ev, ee, seen;
        int lat;
        logic [15:0] c;

        tbl[0] = '{16'h1123, 1, 0, 0, 0, S1};
        tbl[1] = '{16'hA123, 1, 0, 0, 0, S1};
        tbl[2] = '{16'h1234, 0, 0, 0, 0, S2};
        tbl[3] = '{16'h5678, 0, 0, 0, 0, T1};
        tbl[4] = '{16'h5566, 1, 0, 0, 0, T1};
        tbl[5] = '{16'h5687, 0, 1, 2, 2, T2};
        tbl[6] = '{16'h1234, 0, 1, 4, 0, WIN};

        do_reset();
        chk("rst_phase", phase, S1);
        chk("rst_bulls", bulls, 0);
        chk("rst_cows", cows, 0);
        chk("rst_valid", rv, 0);
        chk("rst_err", ce, 0);
        chk("rst_winner", win, 0);
        chk("rst_p1", p1, 0);
        chk("rst_p2", p2, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            press(tbl[i].code);
            settle(gv, ge, lat);
            chk($sformatf("tbl%0d_err", i), ge, tbl[i].err);
            chk($sformatf("tbl%0d_valid", i), gv, tbl[i].val);
            chk($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
            chk($sformatf("tbl%0d_bulls", i), bulls, tbl[i].b);
            chk($sformatf("tbl%0d_cows", i), cows, tbl[i].c);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].val ? 8 : 4);
            if (i == 1) chk("secret1_after_rejects", dut.r_secret1, 16'h0);
        end
        @(negedge clk);
        chk("valid_is_pulse", rv, 0);
        chk("tbl_winner", win, 1);
        chk("tbl_p2", p2, 1);
        chk("tbl_p1", p1, 0);
        chk("tbl_dut2_phase", phase2, WIN);

        press(16'h0000);
        settle(gv, ge, lat);
        chk("win_exit_phase", phase, S1);
        chk("win_exit_s1", dut.r_secret1, 16'h0);
        chk("win_exit_s2", dut.r_secret2, 16'h0);
        chk("win_exit_points_kept", p2, 1);

        do_reset();
        @(negedge clk);
        code  = 16'h1234;
        enter = 1'b1;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_phase", phase, S2);
        chk("held_s1", dut.r_secret1, 16'h1234);
        chk("held_s2", dut.r_secret2, 16'h0);

        do_reset();
        press(16'h1234); settle(gv, ge, lat);
        press(16'h5678); settle(gv, ge, lat);
        press(16'h5687);
        for (int k = 0; k < 20 && phase != S1 + 3'(SCORE); k++) @(negedge clk);
        chk("abort_reached_score", phase, SCORE);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_phase", phase, S1);
        chk("abort_bulls", bulls, 0);
        chk("abort_cows", cows, 0);
        chk("abort_err", ce, 0);
        chk("abort_busy", busy, 0);
        chk("abort_points", {win, p1, p2}, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= rv;
        end
        chk("abort_no_valid", seen, 0);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            press(16'h1234); settle(gv, ge, lat);
            press(16'h5678); settle(gv, ge, lat);
            press(16'h5678); settle(gv, ge, lat);
            if (r == 0) begin
                chk("mp_round1_dut2", phase2, WIN);
                press(16'h0000); settle(gv, ge, lat);
            end
        end
        chk("mp_dut2_phase", phase2, OVER);
        chk("mp_dut2_p1", p1b, 2);
        chk("mp_dut2_winner", win2, 0);
        chk("mp_dut_phase", phase, WIN);
        chk("mp_dut_p1", p1, 2);
        press(16'h1234); settle(gv, ge, lat);
        press(16'h1234); settle(gv, ge, lat);
        chk("over_hold_phase", phase2, OVER);
        chk("over_hold_p1", p1b, 2);
        chk("over_hold_p2", p2b, 0);
        chk("over_hold_bulls", bulls2, 4);
        chk("over_hold_busy", busy2, 0);

        do_reset();
        for (int k = 0; k < 200; k++) begin
            if (m_phase == OVER) do_reset();
            case ($urandom_range(9, 0))
                0, 1: c = 16'($urandom);
                2, 3, 4: c = (m_phase == T1) ? m_s2 : (m_phase == T2) ? m_s1 : rand_legal();
                default: c = rand_legal();
            endcase
            model_press(c, ee, ev);
            press(c);
            settle(gv, ge, lat);
            chk($sformatf("rnd%0d_err", k), ge, ee);
            chk($sformatf("rnd%0d_valid", k), gv, ev);
            chk($sformatf("rnd%0d_phase", k), phase, m_phase);
            chk($sformatf("rnd%0d_bulls", k), bulls, m_b);
            chk($sformatf("rnd%0d_cows", k), cows, m_c);
            chk($sformatf("rnd%0d_winner", k), win, m_win);
            chk($sformatf("rnd%0d_points", k), {p1, p2}, {4'(m_p1), 4'(m_p2)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
